// File: rtl/decode_pkg.sv
// Shared decode types for the IF/ID stage: instruction classes, RV64I major opcodes
// and the immediate formats understood by imm_gen.
package decode_pkg;

  typedef enum logic [3:0] {
    OC_LUI     = 4'd0,
    OC_AUIPC   = 4'd1,
    OC_JAL     = 4'd2,
    OC_JALR    = 4'd3,
    OC_BRANCH  = 4'd4,
    OC_LOAD    = 4'd5,
    OC_STORE   = 4'd6,
    OC_OPIMM   = 4'd7,
    OC_OPIMM32 = 4'd8,
    OC_OP      = 4'd9,
    OC_OP32    = 4'd10,
    OC_SYSTEM  = 4'd11,
    OC_FENCE   = 4'd12,
    OC_ILLEGAL = 4'd13
  } op_class_e;

  typedef enum logic [2:0] {
    IMM_I    = 3'd0,
    IMM_S    = 3'd1,
    IMM_B    = 3'd2,
    IMM_U    = 3'd3,
    IMM_J    = 3'd4,
    IMM_NONE = 3'd5
  } imm_type_e;

  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
  localparam logic [6:0] OPC_FENCE   = 7'b0001111;

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational immediate extractor: picks the RV64I immediate format and
// sign-extends it to XLEN (XLEN must be above 32 for the U-format extension).
module imm_gen
  import decode_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]             instr,
  input  imm_type_e               imm_type,
  output logic signed [XLEN-1:0]  imm
);

  always_comb begin
    imm = '0;
    unique case (imm_type)
      IMM_I: imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
      IMM_S: imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: imm = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U: imm = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};
      IMM_J: imm = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// IF/ID hold register plus RV64I decoder. Read register numbers go to the register
// file combinationally; decoded fields launch into ID/EX on the edge the RF latches data.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int PC_W = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   iid_fetch_valid,
  input  logic [31:0]            iid_fetch_instr,
  input  logic [PC_W-1:0]        iid_fetch_pc,
  output logic                   oid_fetch_ready,
  input  logic                   iid_flush,
  input  logic                   iid_ldst_ec_stall,
  input  logic                   iid_rf_stall,
  output logic [4:0]             oid_read_reg_num0,
  output logic [4:0]             oid_read_reg_num1,
  output logic [4:0]             oid_hazchk_write_reg_num,
  output logic                   oid_hazchk_write_the_register,
  output logic                   oid_valid,
  output logic [PC_W-1:0]        oid_pc,
  output op_class_e              oid_op_class,
  output logic [4:0]             oid_rd,
  output logic [2:0]             oid_funct3,
  output logic                   oid_funct7_b5,
  output logic signed [XLEN-1:0] oid_imm,
  output logic                   oid_illegal
);

  logic                   held_vld_p0;
  logic [31:0]            instr_p0;
  logic [PC_W-1:0]        pc_p0;

  logic                   advance;
  logic                   capture;
  op_class_e              cls_dec;
  imm_type_e              imm_type_dec;
  logic                   writes_rd;
  logic                   uses_rs1;
  logic                   uses_rs2;
  logic                   illegal_dec;
  logic signed [XLEN-1:0] imm_dec;

  assign advance         = held_vld_p0 & ~iid_rf_stall & ~iid_ldst_ec_stall & ~iid_flush;
  assign oid_fetch_ready = ~iid_flush & (~held_vld_p0 | advance);
  assign capture         = iid_fetch_valid & oid_fetch_ready;

  always_comb begin
    cls_dec      = OC_ILLEGAL;
    imm_type_dec = IMM_NONE;
    writes_rd    = 1'b0;
    uses_rs1     = 1'b1;
    uses_rs2     = 1'b0;
    unique case (instr_p0[6:0])
      OPC_LUI:     begin cls_dec = OC_LUI;     imm_type_dec = IMM_U; writes_rd = 1'b1; uses_rs1 = 1'b0; end
      OPC_AUIPC:   begin cls_dec = OC_AUIPC;   imm_type_dec = IMM_U; writes_rd = 1'b1; uses_rs1 = 1'b0; end
      OPC_JAL:     begin cls_dec = OC_JAL;     imm_type_dec = IMM_J; writes_rd = 1'b1; uses_rs1 = 1'b0; end
      OPC_JALR:    begin cls_dec = OC_JALR;    imm_type_dec = IMM_I; writes_rd = 1'b1; end
      OPC_BRANCH:  begin cls_dec = OC_BRANCH;  imm_type_dec = IMM_B; uses_rs2 = 1'b1; end
      OPC_LOAD:    begin cls_dec = OC_LOAD;    imm_type_dec = IMM_I; writes_rd = 1'b1; end
      OPC_STORE:   begin cls_dec = OC_STORE;   imm_type_dec = IMM_S; uses_rs2 = 1'b1; end
      OPC_OPIMM:   begin cls_dec = OC_OPIMM;   imm_type_dec = IMM_I; writes_rd = 1'b1; end
      OPC_OPIMM32: begin cls_dec = OC_OPIMM32; imm_type_dec = IMM_I; writes_rd = 1'b1; end
      OPC_OP:      begin cls_dec = OC_OP;      writes_rd = 1'b1; uses_rs2 = 1'b1; end
      OPC_OP32:    begin cls_dec = OC_OP32;    writes_rd = 1'b1; uses_rs2 = 1'b1; end
      // CSR ops with rd==0 are filtered by the rd!=0 term on the hazard check.
      OPC_SYSTEM:  begin cls_dec = OC_SYSTEM;  imm_type_dec = IMM_I; writes_rd = 1'b1; end
      OPC_FENCE:   begin cls_dec = OC_FENCE;   imm_type_dec = IMM_I; uses_rs1 = 1'b0; end
      default:     ;
    endcase
    illegal_dec = (cls_dec == OC_ILLEGAL);
  end

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr    (instr_p0),
    .imm_type (imm_type_dec),
    .imm      (imm_dec)
  );

  // Unused source registers read as x0, which the scoreboard never marks busy.
  assign oid_read_reg_num0             = (held_vld_p0 & uses_rs1) ? instr_p0[19:15] : 5'd0;
  assign oid_read_reg_num1             = (held_vld_p0 & uses_rs2) ? instr_p0[24:20] : 5'd0;
  assign oid_hazchk_write_reg_num      = held_vld_p0 ? instr_p0[11:7] : 5'd0;
  assign oid_hazchk_write_the_register = held_vld_p0 & writes_rd & (instr_p0[11:7] != 5'd0) & ~iid_flush;

  // p0 -> ID/EX boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      held_vld_p0   <= 1'b0;
      oid_valid     <= 1'b0;
      oid_pc        <= '0;
      oid_op_class  <= op_class_e'(4'd0);
      oid_rd        <= '0;
      oid_funct3    <= '0;
      oid_funct7_b5 <= 1'b0;
      oid_imm       <= '0;
      oid_illegal   <= 1'b0;
    end else begin
      if (iid_flush)    held_vld_p0 <= 1'b0;
      else if (capture) held_vld_p0 <= 1'b1;
      else if (advance) held_vld_p0 <= 1'b0;

      if (capture) begin
        instr_p0 <= iid_fetch_instr;
        pc_p0    <= iid_fetch_pc;
      end

      if (iid_flush) begin
        oid_valid <= 1'b0;
      end else if (!iid_ldst_ec_stall) begin
        oid_valid <= advance;
        if (advance) begin
          oid_pc        <= pc_p0;
          oid_op_class  <= cls_dec;
          oid_rd        <= instr_p0[11:7];
          oid_funct3    <= instr_p0[14:12];
          oid_funct7_b5 <= instr_p0[30];
          oid_imm       <= imm_dec;
          oid_illegal   <= illegal_dec;
        end
      end
    end
  end

endmodule
